// File: rtl/axi4lite_regfile_if.sv
// AXI4-Lite bus bundle between one master and the register-file slave.
// The address/write channels flow master->slave; the responses flow back.
interface axi4lite_regfile_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int STRB_W = DATA_W/8
);
  logic              AW_VALID;
  logic [ADDR_W-1:0] AW_ADDR;
  logic [2:0]        AW_PROT;
  logic              AW_READY;
  logic              W_VALID;
  logic [DATA_W-1:0] W_DATA;
  logic [STRB_W-1:0] W_STRB;
  logic              W_READY;
  logic              B_VALID;
  logic [1:0]        B_RESP;
  logic              B_READY;
  logic              AR_VALID;
  logic [ADDR_W-1:0] AR_ADDR;
  logic [2:0]        AR_PROT;
  logic              AR_READY;
  logic              R_VALID;
  logic [DATA_W-1:0] R_DATA;
  logic [1:0]        R_RESP;
  logic              R_READY;

  modport master (
    output AW_VALID, AW_ADDR, AW_PROT, input AW_READY,
    output W_VALID, W_DATA, W_STRB,    input W_READY,
    input  B_VALID, B_RESP,            output B_READY,
    output AR_VALID, AR_ADDR, AR_PROT, input AR_READY,
    input  R_VALID, R_DATA, R_RESP,    output R_READY
  );

  modport slave (
    input  AW_VALID, AW_ADDR, AW_PROT, output AW_READY,
    input  W_VALID, W_DATA, W_STRB,    output W_READY,
    output B_VALID, B_RESP,            input B_READY,
    input  AR_VALID, AR_ADDR, AR_PROT, output AR_READY,
    output R_VALID, R_DATA, R_RESP,    input R_READY
  );
endinterface

// File: rtl/axi4lite_regfile.sv
// AXI4-Lite slave terminating in NUM_REGS 32-bit control registers.
// Independent write and read FSMs; out-of-range accesses answer SLVERR.
module axi4lite_regfile #(
  parameter int AXI_ADDR_WIDTH = 32,
  parameter int AXI_DATA_WIDTH = 32,
  parameter int AXI_STRB_WIDTH = AXI_DATA_WIDTH/8,
  parameter int NUM_REGS       = 8
) (
  input  logic                               A_CLK,
  input  logic                               A_RST,
  axi4lite_regfile_if.slave                  bus,
  output logic [NUM_REGS*AXI_DATA_WIDTH-1:0] regs_o,
  output logic [NUM_REGS-1:0]                wr_pulse_o
);
  localparam int IDX_W = $clog2(NUM_REGS);
  localparam logic [AXI_ADDR_WIDTH-1:0] LIMIT = AXI_ADDR_WIDTH'(NUM_REGS*4);
  localparam logic [1:0] OKAY = 2'b00, SLVERR = 2'b10;

  typedef enum logic {WR_IDLE, WR_RESP} wr_state_e;
  typedef enum logic {RD_IDLE, RD_DATA} rd_state_e;

  wr_state_e wr_q;
  rd_state_e rd_q;

  logic [NUM_REGS-1:0][AXI_DATA_WIDTH-1:0] regs_q;
  logic [NUM_REGS-1:0]       wr_pulse_q;
  logic                      aw_held_q, w_held_q;
  logic [AXI_ADDR_WIDTH-1:0] awaddr_q;
  logic [AXI_DATA_WIDTH-1:0] wdata_q;
  logic [AXI_STRB_WIDTH-1:0] wstrb_q;
  logic                      b_valid_q, r_valid_q;
  logic [1:0]                b_resp_q, r_resp_q;
  logic [AXI_DATA_WIDTH-1:0] r_data_q;

  logic                      aw_hs, w_hs, ar_hs, wr_go, wr_in_range, rd_in_range;
  logic [AXI_ADDR_WIDTH-1:0] waddr_d;
  logic [AXI_DATA_WIDTH-1:0] wdata_d;
  logic [AXI_STRB_WIDTH-1:0] wstrb_d;
  logic [IDX_W-1:0]          widx, ridx;
  logic                      unused_prot;

  assign unused_prot = ^{bus.AW_PROT, bus.AR_PROT};

  // Readies are forced low while reset is held, so they rise with release.
  assign bus.AW_READY = !A_RST && (wr_q == WR_IDLE) && !aw_held_q;
  assign bus.W_READY  = !A_RST && (wr_q == WR_IDLE) && !w_held_q;
  assign bus.AR_READY = !A_RST && (rd_q == RD_IDLE);

  assign aw_hs = bus.AW_VALID && bus.AW_READY;
  assign w_hs  = bus.W_VALID  && bus.W_READY;
  assign ar_hs = bus.AR_VALID && bus.AR_READY;

  // Take whichever half arrives this cycle, else the latched copy.
  assign waddr_d     = aw_hs ? bus.AW_ADDR : awaddr_q;
  assign wdata_d     = w_hs  ? bus.W_DATA  : wdata_q;
  assign wstrb_d     = w_hs  ? bus.W_STRB  : wstrb_q;
  assign wr_go       = (aw_hs || aw_held_q) && (w_hs || w_held_q);
  assign wr_in_range = waddr_d < LIMIT;
  assign widx        = waddr_d[2 +: IDX_W];
  assign rd_in_range = bus.AR_ADDR < LIMIT;
  assign ridx        = bus.AR_ADDR[2 +: IDX_W];

  always_ff @(posedge A_CLK or posedge A_RST) begin
    if (A_RST) begin
      wr_q       <= WR_IDLE;
      regs_q     <= '0;
      wr_pulse_q <= '0;
      aw_held_q  <= 1'b0;
      w_held_q   <= 1'b0;
      awaddr_q   <= '0;
      wdata_q    <= '0;
      wstrb_q    <= '0;
      b_valid_q  <= 1'b0;
      b_resp_q   <= OKAY;
    end else begin
      wr_pulse_q <= '0;
      case (wr_q)
        WR_IDLE: begin
          if (aw_hs) begin
            awaddr_q  <= bus.AW_ADDR;
            aw_held_q <= 1'b1;
          end
          if (w_hs) begin
            wdata_q  <= bus.W_DATA;
            wstrb_q  <= bus.W_STRB;
            w_held_q <= 1'b1;
          end
          if (wr_go) begin
            aw_held_q <= 1'b0;
            w_held_q  <= 1'b0;
            b_valid_q <= 1'b1;
            b_resp_q  <= wr_in_range ? OKAY : SLVERR;
            if (wr_in_range) begin
              for (int b = 0; b < AXI_STRB_WIDTH; b++)
                if (wstrb_d[b]) regs_q[widx][8*b +: 8] <= wdata_d[8*b +: 8];
              wr_pulse_q[widx] <= 1'b1;
            end
            wr_q <= WR_RESP;
          end
        end
        WR_RESP: begin
          if (bus.B_READY) begin
            b_valid_q <= 1'b0;
            wr_q      <= WR_IDLE;
          end
        end
        default: wr_q <= WR_IDLE;
      endcase
    end
  end

  // regs_q is sampled before the write block's update, so a same-edge read sees the old value.
  always_ff @(posedge A_CLK or posedge A_RST) begin
    if (A_RST) begin
      rd_q      <= RD_IDLE;
      r_valid_q <= 1'b0;
      r_resp_q  <= OKAY;
      r_data_q  <= '0;
    end else begin
      case (rd_q)
        RD_IDLE: begin
          if (ar_hs) begin
            r_valid_q <= 1'b1;
            r_resp_q  <= rd_in_range ? OKAY : SLVERR;
            r_data_q  <= rd_in_range ? regs_q[ridx] : '0;
            rd_q      <= RD_DATA;
          end
        end
        RD_DATA: begin
          if (bus.R_READY) begin
            r_valid_q <= 1'b0;
            rd_q      <= RD_IDLE;
          end
        end
        default: rd_q <= RD_IDLE;
      endcase
    end
  end

  assign bus.B_VALID = b_valid_q;
  assign bus.B_RESP  = b_resp_q;
  assign bus.R_VALID = r_valid_q;
  assign bus.R_RESP  = r_resp_q;
  assign bus.R_DATA  = r_data_q;
  assign regs_o      = regs_q;
  assign wr_pulse_o  = wr_pulse_q;
endmodule

// File: tb/tb_axi4lite_regfile.sv
// Directed plus randomized checks of axi4lite_regfile against an array model
// of eight byte-strobed registers with SLVERR outside 0x00..0x1F.
module tb_axi4lite_regfile;
  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [255:0] regs;
  logic [7:0]   pulse;
  int           vectors = 0;
  int           miscompares = 0;
  logic [31:0]  model [8];

  axi4lite_regfile_if #(.ADDR_W(32), .DATA_W(32), .STRB_W(4)) bus ();

  axi4lite_regfile #(
    .AXI_ADDR_WIDTH(32), .AXI_DATA_WIDTH(32), .AXI_STRB_WIDTH(4), .NUM_REGS(8)
  ) dut (
    .A_CLK(clk), .A_RST(rst), .bus(bus), .regs_o(regs), .wr_pulse_o(pulse)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [255:0] model_vec();
    logic [255:0] v;
    for (int k = 0; k < 8; k++) v[32*k +: 32] = model[k];
    return v;
  endfunction

  function automatic bit in_range(input logic [31:0] a);
    return a < 32'd32;
  endfunction

  function automatic int idx_of(input logic [31:0] a);
    return int'((a / 4) % 8);
  endfunction

  function automatic void model_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
    if (in_range(a))
      for (int b = 0; b < 4; b++)
        if (s[b]) model[idx_of(a)][8*b +: 8] = d[8*b +: 8];
  endfunction

  task automatic do_write(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb);
    bit aw_done, w_done;
    int n;
    logic [7:0] exp_pulse;
    aw_done = 0; w_done = 0; n = 0;
    bus.AW_VALID = 1'b1; bus.AW_ADDR = addr; bus.AW_PROT = 3'($urandom);
    bus.W_VALID = 1'b1; bus.W_DATA = data; bus.W_STRB = strb;
    bus.B_READY = 1'b0;
    while (!(aw_done && w_done) && n < 20) begin
      bit aw_acc, w_acc;
      aw_acc = bus.AW_VALID && bus.AW_READY;
      w_acc  = bus.W_VALID && bus.W_READY;
      step();
      n++;
      if (aw_acc) begin aw_done = 1; bus.AW_VALID = 1'b0; end
      if (w_acc)  begin w_done = 1;  bus.W_VALID = 1'b0;  end
    end
    bus.AW_VALID = 1'b0; bus.W_VALID = 1'b0;
    chk("wr_accept", 256'(aw_done && w_done), 256'(1));
    exp_pulse = in_range(addr) ? 8'(1 << idx_of(addr)) : 8'h00;
    model_write(addr, data, strb);
    chk("b_valid", 256'(bus.B_VALID), 256'(1));
    chk("b_resp", 256'(bus.B_RESP), in_range(addr) ? 256'(0) : 256'(2));
    chk("wr_regs", regs, model_vec());
    chk("wr_pulse", 256'(pulse), 256'(exp_pulse));
    bus.B_READY = 1'b1;
    step();
    bus.B_READY = 1'b0;
    chk("b_done", 256'(bus.B_VALID), 256'(0));
    chk("pulse_clear", 256'(pulse), 256'(0));
  endtask

  task automatic do_read(input logic [31:0] addr);
    int n;
    logic [31:0] exp_data;
    n = 0;
    bus.AR_VALID = 1'b1; bus.AR_ADDR = addr; bus.AR_PROT = 3'($urandom);
    while (!bus.AR_READY && n < 20) begin step(); n++; end
    chk("ar_ready", 256'(bus.AR_READY), 256'(1));
    exp_data = in_range(addr) ? model[idx_of(addr)] : 32'h0;
    step();
    bus.AR_VALID = 1'b0;
    chk("r_valid", 256'(bus.R_VALID), 256'(1));
    chk("r_data", 256'(bus.R_DATA), 256'(exp_data));
    chk("r_resp", 256'(bus.R_RESP), in_range(addr) ? 256'(0) : 256'(2));
    bus.R_READY = 1'b1;
    step();
    bus.R_READY = 1'b0;
    chk("r_done", 256'(bus.R_VALID), 256'(0));
  endtask

  initial begin
    logic [31:0] a, d, old;
    logic [3:0]  s;
    bus.AW_VALID = 0; bus.AW_ADDR = 0; bus.AW_PROT = 0;
    bus.W_VALID = 0;  bus.W_DATA = 0;  bus.W_STRB = 0;  bus.B_READY = 0;
    bus.AR_VALID = 0; bus.AR_ADDR = 0; bus.AR_PROT = 0; bus.R_READY = 0;
    for (int k = 0; k < 8; k++) model[k] = 32'h0;

    // Reset state
    step(); step();
    chk("rst_aw_ready", 256'(bus.AW_READY), 256'(0));
    chk("rst_ar_ready", 256'(bus.AR_READY), 256'(0));
    chk("rst_b_valid", 256'(bus.B_VALID), 256'(0));
    chk("rst_regs", regs, 256'(0));
    rst = 1'b0;
    #1;
    chk("rel_aw_ready", 256'(bus.AW_READY), 256'(1));
    chk("rel_w_ready", 256'(bus.W_READY), 256'(1));
    chk("rel_ar_ready", 256'(bus.AR_READY), 256'(1));
    step();

    for (int k = 0; k < 8; k++) do_read(32'(4*k));

    // Same-cycle AW/W, then readback
    do_write(32'h08, 32'hDEADBEEF, 4'hF);
    chk("reg2_value", 256'(regs[95:64]), 256'(32'hDEADBEEF));
    do_read(32'h08);

    // Partial strobe
    do_write(32'h04, 32'hDEADBEEF, 4'hF);
    do_write(32'h04, 32'h11223344, 4'b0101);
    chk("partial_strb", 256'(regs[63:32]), 256'(32'hDE22BE44));

    // Skewed channels: W first, AW three cycles later, B_READY held low
    bus.W_VALID = 1'b1; bus.W_DATA = 32'hA5A55A5A; bus.W_STRB = 4'hF;
    step();
    bus.W_VALID = 1'b0;
    chk("skew_w_ready_low", 256'(bus.W_READY), 256'(0));
    chk("skew_aw_ready_high", 256'(bus.AW_READY), 256'(1));
    step(); step();
    chk("skew_no_b_yet", 256'(bus.B_VALID), 256'(0));
    bus.AW_VALID = 1'b1; bus.AW_ADDR = 32'h04;
    step();
    bus.AW_VALID = 1'b0;
    model_write(32'h04, 32'hA5A55A5A, 4'hF);
    chk("skew_pulse", 256'(pulse), 256'(8'h02));
    for (int i = 0; i < 5; i++) begin
      chk("skew_b_hold", 256'(bus.B_VALID), 256'(1));
      chk("skew_b_resp", 256'(bus.B_RESP), 256'(0));
      chk("skew_ready_low", 256'(bus.AW_READY || bus.W_READY), 256'(0));
      step();
    end
    chk("skew_regs", regs, model_vec());
    bus.B_READY = 1'b1;
    step();
    bus.B_READY = 1'b0;
    chk("skew_ready_back", 256'(bus.AW_READY && bus.W_READY), 256'(1));

    // Out-of-range
    do_write(32'h40, 32'hFFFFFFFF, 4'hF);
    do_read(32'h40);

    // Zero strobe in range
    do_write(32'h0C, 32'h12345678, 4'h0);

    // Same-edge read and write of one register returns the pre-write value
    old = model[2];
    bus.AW_VALID = 1'b1; bus.AW_ADDR = 32'h08;
    bus.W_VALID = 1'b1;  bus.W_DATA = 32'hCAFEF00D; bus.W_STRB = 4'hF;
    bus.AR_VALID = 1'b1; bus.AR_ADDR = 32'h08;
    step();
    bus.AW_VALID = 1'b0; bus.W_VALID = 1'b0; bus.AR_VALID = 1'b0;
    model_write(32'h08, 32'hCAFEF00D, 4'hF);
    chk("rw_same_rdata", 256'(bus.R_DATA), 256'(old));
    chk("rw_same_regs", regs, model_vec());
    bus.B_READY = 1'b1; bus.R_READY = 1'b1;
    step();
    bus.B_READY = 1'b0; bus.R_READY = 1'b0;

    // Randomized traffic
    for (int i = 0; i < 80; i++) begin
      a = 32'($urandom_range(0, 19) * 4 + $urandom_range(0, 3));
      d = $urandom;
      s = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 1) == 1) do_write(a, d, s);
      else do_read(a);
    end

    // Reset with B and R both pending
    bus.AW_VALID = 1'b1; bus.AW_ADDR = 32'h10;
    bus.W_VALID = 1'b1;  bus.W_DATA = 32'h5555AAAA; bus.W_STRB = 4'hF;
    bus.AR_VALID = 1'b1; bus.AR_ADDR = 32'h10;
    step();
    bus.AW_VALID = 1'b0; bus.W_VALID = 1'b0; bus.AR_VALID = 1'b0;
    chk("pend_b", 256'(bus.B_VALID), 256'(1));
    chk("pend_r", 256'(bus.R_VALID), 256'(1));
    rst = 1'b1;
    #1;
    chk("mid_rst_b", 256'(bus.B_VALID), 256'(0));
    chk("mid_rst_r", 256'(bus.R_VALID), 256'(0));
    chk("mid_rst_regs", regs, 256'(0));
    chk("mid_rst_pulse", 256'(pulse), 256'(0));
    chk("mid_rst_rdata", 256'(bus.R_DATA), 256'(0));
    chk("mid_rst_ready", 256'(bus.AW_READY || bus.W_READY || bus.AR_READY), 256'(0));
    for (int k = 0; k < 8; k++) model[k] = 32'h0;
    step();
    rst = 1'b0;
    bus.B_READY = 1'b1; bus.R_READY = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      chk("post_rst_no_b", 256'(bus.B_VALID), 256'(0));
      chk("post_rst_no_r", 256'(bus.R_VALID), 256'(0));
    end
    bus.B_READY = 1'b0; bus.R_READY = 1'b0;
    chk("post_rst_regs", regs, 256'(0));
    do_read(32'h10);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
